// File: rtl/jpeg_out_sched_if.sv
// Frame-writeback bus: MCU buffer read port plus frame-memory write handshake.
// mem_wr_data narrows to 16 bits when JPEG_OUT_RGB565_EN is defined.
interface jpeg_out_sched_if #(
  parameter int ADDR_W = 24,
  parameter int PIX_W  = 24
);
`ifdef JPEG_OUT_RGB565_EN
  localparam int OUT_W = 16;
`else
  localparam int OUT_W = PIX_W;
`endif

  logic              buf_rd_en;
  logic [7:0]        buf_rd_addr;
  logic [PIX_W-1:0]  buf_rd_data;
  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [OUT_W-1:0]  mem_wr_data;

  modport master (
    output buf_rd_en, buf_rd_addr,
    input  buf_rd_data,
    output mem_wr_valid, mem_wr_addr, mem_wr_data,
    input  mem_wr_ready
  );

  modport slave (
    input  buf_rd_en, buf_rd_addr,
    output buf_rd_data,
    input  mem_wr_valid, mem_wr_addr, mem_wr_data,
    output mem_wr_ready
  );
endinterface

// File: rtl/jpeg_out_sched.sv
// MCU writeback scheduler: raster walk of the MCU buffer, one frame write per visible pixel.
// 3 cycles per visible pixel, 1 per clipped pixel, +2 per MCU; mem_wr_ready stalls WR. RGB565 output via JPEG_OUT_RGB565_EN.
module jpeg_out_sched #(
  parameter int ADDR_W = 24,
  parameter int PIX_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mcu_go,
  input  logic              pic_is_411,
  input  logic [12:0]       x_mcu,
  input  logic [12:0]       y_mcu,
  input  logic [12:0]       mcu_w,
  input  logic [12:0]       mcu_h,
  input  logic [15:0]       width,
  input  logic [15:0]       heigth,
  input  logic [ADDR_W-1:0] frame_base,
  jpeg_out_sched_if.master  bus,
  output logic              out_empty,
  output logic              mcu_done,
  output logic              frame_done,
  output logic              ovf_err
);
  localparam int SUM_W = (ADDR_W > 33) ? ADDR_W : 33;

  typedef enum logic [2:0] {IDLE, CHK, RD, WR, DONE} state_t;

  state_t            state;
  logic              is411_q;
  logic [12:0]       x_q;
  logic [12:0]       y_q;
  logic [3:0]        px;
  logic [3:0]        py;
  logic              wr_first;
  logic [PIX_W-1:0]  data_q;

  logic [3:0]        n_m1;
  logic [16:0]       base_x;
  logic [16:0]       base_y;
  logic [16:0]       pix_x;
  logic [16:0]       pix_y;
  logic [32:0]       lin;
  logic              visible;
  logic              last_pix;
  logic [3:0]        px_nx;
  logic [3:0]        py_nx;
  logic [7:0]        rd_idx;
  logic [ADDR_W-1:0] addr_next;
  logic [PIX_W-1:0]  pix_out;
  logic              is_frame_end;

  always_comb begin
    n_m1      = is411_q ? 4'd15 : 4'd7;
    base_x    = is411_q ? {x_q, 4'b0} : {1'b0, x_q, 3'b0};
    base_y    = is411_q ? {y_q, 4'b0} : {1'b0, y_q, 3'b0};
    pix_x     = base_x + {13'b0, px};
    pix_y     = base_y + {13'b0, py};
    lin       = {16'b0, pix_y} * {17'b0, width};
    visible   = (pix_x < {1'b0, width}) && (pix_y < {1'b0, heigth});
    last_pix  = (px == n_m1) && (py == n_m1);
    px_nx     = (px == n_m1) ? 4'd0 : px + 4'd1;
    py_nx     = (px == n_m1) ? py + 4'd1 : py;
    rd_idx    = is411_q ? {py, px} : {2'b0, py[2:0], px[2:0]};
    addr_next = ADDR_W'(SUM_W'(frame_base) + SUM_W'(lin) + SUM_W'(pix_x));
    is_frame_end = (x_q == mcu_w - 13'd1) && (y_q == mcu_h - 13'd1);
  end

  // Buffer data arrives in the first WR cycle; it is bypassed then and held from the register afterwards.
  assign pix_out = wr_first ? bus.buf_rd_data : data_q;

`ifdef JPEG_OUT_RGB565_EN
  assign bus.mem_wr_data = {pix_out[23:19], pix_out[15:10], pix_out[7:3]};
`else
  assign bus.mem_wr_data = pix_out;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      is411_q          <= 1'b0;
      x_q              <= '0;
      y_q              <= '0;
      px               <= '0;
      py               <= '0;
      wr_first         <= 1'b0;
      data_q           <= '0;
      bus.buf_rd_en    <= 1'b0;
      bus.buf_rd_addr  <= '0;
      bus.mem_wr_valid <= 1'b0;
      bus.mem_wr_addr  <= '0;
      out_empty        <= 1'b1;
      mcu_done         <= 1'b0;
      frame_done       <= 1'b0;
      ovf_err          <= 1'b0;
    end else begin
      mcu_done   <= 1'b0;
      frame_done <= 1'b0;
      if (mcu_go && state != IDLE)
        ovf_err <= 1'b1;

      case (state)
        IDLE: begin
          if (mcu_go) begin
            is411_q   <= pic_is_411;
            x_q       <= x_mcu;
            y_q       <= y_mcu;
            px        <= '0;
            py        <= '0;
            out_empty <= 1'b0;
            state     <= CHK;
          end
        end
        CHK: begin
          if (visible) begin
            bus.buf_rd_en   <= 1'b1;
            bus.buf_rd_addr <= rd_idx;
            bus.mem_wr_addr <= addr_next;
            state           <= RD;
          end else begin
            px <= px_nx;
            py <= py_nx;
            if (last_pix) begin
              mcu_done   <= 1'b1;
              frame_done <= is_frame_end;
              state      <= DONE;
            end else begin
              state <= CHK;
            end
          end
        end
        RD: begin
          bus.buf_rd_en    <= 1'b0;
          bus.mem_wr_valid <= 1'b1;
          wr_first         <= 1'b1;
          state            <= WR;
        end
        WR: begin
          wr_first <= 1'b0;
          if (wr_first)
            data_q <= bus.buf_rd_data;
          if (bus.mem_wr_ready) begin
            bus.mem_wr_valid <= 1'b0;
            px <= px_nx;
            py <= py_nx;
            if (last_pix) begin
              mcu_done   <= 1'b1;
              frame_done <= is_frame_end;
              state      <= DONE;
            end else begin
              state <= CHK;
            end
          end
        end
        DONE: begin
          out_empty <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jpeg_out_sched.sv
// Bench for jpeg_out_sched: MCU vector table with a write scoreboard, plus stall, overflow and reset sequences.
`timescale 1ns/1ps
module tb_jpeg_out_sched;
  localparam int ADDR_W = 24;
  localparam int PIX_W  = 24;
`ifdef JPEG_OUT_RGB565_EN
  localparam int OUT_W = 16;
  localparam logic [15:0] EXP_PX0 = 16'hFC08;
`else
  localparam int OUT_W = 24;
  localparam logic [23:0] EXP_PX0 = 24'hFF8040;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  data;
  } wr_t;

  typedef struct {
    logic        is411;
    int          x, y, mw, mh, w, h;
    logic [23:0] base;
    int          nwr, lat;
    logic        fd;
    logic [23:0] first, last;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              mcu_go = 1'b0;
  logic              pic_is_411 = 1'b0;
  logic [12:0]       x_mcu = '0, y_mcu = '0, mcu_w = '0, mcu_h = '0;
  logic [15:0]       width = '0, heigth = '0;
  logic [ADDR_W-1:0] frame_base = '0;
  logic              ready = 1'b1;
  logic              out_empty, mcu_done, frame_done, ovf_err;

  logic [PIX_W-1:0]  bufmem [256];
  wr_t               sb [$];
  vec_t              vecs [6];
  int                checks = 0;
  int                errors = 0;
  int                wr_seen = 0;
  logic              first_pending = 1'b0;
  logic [ADDR_W-1:0] first_addr, last_addr;
  logic [OUT_W-1:0]  first_data;
  int                lat, base_wr;
  logic              fd;
  logic [ADDR_W-1:0] hold_a;
  logic [OUT_W-1:0]  hold_d;

  always #5 clk = ~clk;

  jpeg_out_sched_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();
  assign bus.mem_wr_ready = ready;

  jpeg_out_sched #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mcu_go     (mcu_go),
    .pic_is_411 (pic_is_411),
    .x_mcu      (x_mcu),
    .y_mcu      (y_mcu),
    .mcu_w      (mcu_w),
    .mcu_h      (mcu_h),
    .width      (width),
    .heigth     (heigth),
    .frame_base (frame_base),
    .bus        (bus.master),
    .out_empty  (out_empty),
    .mcu_done   (mcu_done),
    .frame_done (frame_done),
    .ovf_err    (ovf_err)
  );

  // Synchronous buffer: data appears the cycle after the read strobe and holds until the next read.
  always @(posedge clk)
    if (bus.buf_rd_en) bus.buf_rd_data <= bufmem[bus.buf_rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] conv(input logic [23:0] p);
`ifdef JPEG_OUT_RGB565_EN
    return {p[23:19], p[15:10], p[7:3]};
`else
    return p;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.mem_wr_valid && ready) begin
      wr_seen++;
      if (first_pending) begin
        first_addr    = bus.mem_wr_addr;
        first_data    = bus.mem_wr_data;
        first_pending = 1'b0;
      end
      last_addr = bus.mem_wr_addr;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", bus.mem_wr_addr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(bus.mem_wr_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.mem_wr_data), 64'(e.data));
      end
    end
  end

  task automatic push_expected(input vec_t v);
    int n;
    longint xx, yy, a;
    n = v.is411 ? 16 : 8;
    for (int py = 0; py < n; py++)
      for (int px = 0; px < n; px++) begin
        xx = longint'(v.x) * n + px;
        yy = longint'(v.y) * n + py;
        if (xx < v.w && yy < v.h) begin
          wr_t e;
          a = longint'(v.base) + yy * v.w + xx;
          e.addr = a[ADDR_W-1:0];
          e.data = conv(bufmem[py*n+px]);
          sb.push_back(e);
        end
      end
  endtask

  task automatic apply_cfg(input vec_t v);
    pic_is_411 = v.is411;
    x_mcu      = 13'(v.x);
    y_mcu      = 13'(v.y);
    mcu_w      = 13'(v.mw);
    mcu_h      = 13'(v.mh);
    width      = 16'(v.w);
    heigth     = 16'(v.h);
    frame_base = v.base;
  endtask

  // Latency counts cycles inclusively: the mcu_go cycle through the mcu_done cycle.
  task automatic run_mcu(input vec_t v, output int l, output logic f);
    int cnt;
    bit seen;
    push_expected(v);
    apply_cfg(v);
    first_pending = 1'b1;
    mcu_go = 1'b1;
    @(posedge clk); #1;
    mcu_go = 1'b0;
    cnt = 1;
    chk("out_empty_busy", 64'(out_empty), 64'd0);
    seen = 0;
    f = 1'b0;
    while (cnt < 3000) begin
      if (mcu_done) begin
        seen = 1;
        f = frame_done;
        break;
      end
      @(posedge clk); #1;
      cnt++;
    end
    chk("mcu_done_seen", 64'(seen), 64'd1);
    l = cnt + 1;
    @(posedge clk); #1;
    chk("mcu_done_pulse", 64'(mcu_done), 64'd0);
    chk("out_empty_after", 64'(out_empty), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      bufmem[i] = {8'(i * 3), 8'(i) ^ 8'hA5, ~8'(i)};
    bufmem[0] = 24'hFF8040;

    //           411  x  y mw mh   w   h  base        nwr  lat  fd first      last
    vecs[0] = '{1'b0, 1, 0, 2, 2, 16, 16, 24'h001000,  64, 194, 1'b0, 24'h001008, 24'h00107F};
    vecs[1] = '{1'b1, 1, 0, 2, 1, 20, 10, 24'h000000,  40, 338, 1'b1, 24'h000010, 24'h0000C7};
    vecs[2] = '{1'b0, 0, 0, 1, 1,  5,  3, 24'h000200,  15,  96, 1'b1, 24'h000200, 24'h00020E};
    vecs[3] = '{1'b0, 2, 0, 3, 1, 16, 16, 24'h000000,   0,  66, 1'b1, 24'h000000, 24'h000000};
    vecs[4] = '{1'b1, 0, 0, 1, 1, 16, 16, 24'hFFFFF0, 256, 770, 1'b1, 24'hFFFFF0, 24'h0000EF};
    vecs[5] = '{1'b0, 0, 1, 2, 2,  8, 12, 24'h000040,  32, 130, 1'b0, 24'h000080, 24'h00009F};

    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_out_empty", 64'(out_empty), 64'd1);
    chk("rst_wr_valid", 64'(bus.mem_wr_valid), 64'd0);
    chk("rst_rd_en", 64'(bus.buf_rd_en), 64'd0);
    chk("rst_mcu_done", 64'(mcu_done), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_ovf_err", 64'(ovf_err), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      base_wr = wr_seen;
      run_mcu(vecs[i], lat, fd);
      chk($sformatf("v%0d_writes", i), 64'(wr_seen - base_wr), 64'(vecs[i].nwr));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_frame_done", i), 64'(fd), 64'(vecs[i].fd));
      chk($sformatf("v%0d_sb_empty", i), 64'(sb.size()), 64'd0);
      chk($sformatf("v%0d_ovf", i), 64'(ovf_err), 64'd0);
      if (vecs[i].nwr > 0) begin
        chk($sformatf("v%0d_first_addr", i), 64'(first_addr), 64'(vecs[i].first));
        chk($sformatf("v%0d_last_addr", i), 64'(last_addr), 64'(vecs[i].last));
      end
      if (i == 0)
        chk("px0_data", 64'(first_data), 64'(EXP_PX0));
      repeat (2) @(posedge clk);
      #1;
    end

    // Five-cycle stall on the third write.
    base_wr = wr_seen;
    fork
      run_mcu(vecs[0], lat, fd);
      begin
        int t;
        t = 0;
        while (wr_seen < base_wr + 2 && t < 1000) begin @(posedge clk); #1; t++; end
        ready = 1'b0;
        t = 0;
        while (!bus.mem_wr_valid && t < 20) begin @(posedge clk); #1; t++; end
        hold_a = bus.mem_wr_addr;
        hold_d = bus.mem_wr_data;
        chk("stall_addr_3rd", 64'(hold_a), 64'h100A);
        for (int k = 0; k < 5; k++) begin
          chk("stall_valid", 64'(bus.mem_wr_valid), 64'd1);
          chk("stall_addr_hold", 64'(bus.mem_wr_addr), 64'(hold_a));
          chk("stall_data_hold", 64'(bus.mem_wr_data), 64'(hold_d));
          @(posedge clk); #1;
        end
        ready = 1'b1;
      end
    join
    chk("stall_writes", 64'(wr_seen - base_wr), 64'd64);
    chk("stall_latency", 64'(lat), 64'd199);
    chk("stall_sb_empty", 64'(sb.size()), 64'd0);

    // Second mcu_go while busy.
    repeat (2) @(posedge clk);
    #1;
    base_wr = wr_seen;
    fork
      run_mcu(vecs[0], lat, fd);
      begin
        repeat (10) @(posedge clk);
        #1 mcu_go = 1'b1;
        @(posedge clk); #1 mcu_go = 1'b0;
        chk("ovf_set", 64'(ovf_err), 64'd1);
      end
    join
    chk("ovf_writes", 64'(wr_seen - base_wr), 64'd64);
    chk("ovf_latency", 64'(lat), 64'd194);
    repeat (20) @(posedge clk);
    #1;
    chk("ovf_no_second_mcu", 64'(wr_seen - base_wr), 64'd64);
    chk("ovf_idle_empty", 64'(out_empty), 64'd1);
    chk("ovf_sticky", 64'(ovf_err), 64'd1);

    // Reset asserted while a write is stalled.
    ready = 1'b0;
    apply_cfg(vecs[0]);
    mcu_go = 1'b1;
    @(posedge clk); #1 mcu_go = 1'b0;
    for (int t = 0; t < 20 && !bus.mem_wr_valid; t++) begin @(posedge clk); #1; end
    chk("pre_rst_valid", 64'(bus.mem_wr_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.mem_wr_valid), 64'd0);
    chk("mid_rst_empty", 64'(out_empty), 64'd1);
    chk("mid_rst_ovf", 64'(ovf_err), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 64'(mcu_done), 64'd0);
    rst = 1'b1;
    ready = 1'b1;
    @(posedge clk); #1;
    base_wr = wr_seen;
    run_mcu(vecs[0], lat, fd);
    chk("post_rst_writes", 64'(wr_seen - base_wr), 64'd64);
    chk("post_rst_latency", 64'(lat), 64'd194);
    chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
